// File: rtl/uart_cmd_pkg.sv
// ============================================================================
//  Module  : uart_cmd_pkg
//  Brief   : Shared state encoding, command/response codes and phase helpers
//            for the UART command responder.
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package uart_cmd_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_W_ADDR = 3'd1,
        ST_W_DATA = 3'd2,
        ST_R_ADDR = 3'd3,
        ST_BUS    = 3'd4,
        ST_RESP   = 3'd5
    } state_t;

    localparam logic [7:0] CMD_WRITE = 8'h57;
    localparam logic [7:0] CMD_READ  = 8'h52;
    localparam logic [7:0] RSP_ACK   = 8'h06;
    localparam logic [7:0] RSP_NAK   = 8'h15;

    // States in which the responder is willing to take a received byte.
    function automatic logic rx_phase(input state_t s);
        return (s == ST_IDLE) || (s == ST_W_ADDR) || (s == ST_W_DATA) || (s == ST_R_ADDR);
    endfunction

    // States in the middle of a packet, where the inter-byte timeout runs.
    function automatic logic pkt_phase(input state_t s);
        return (s == ST_W_ADDR) || (s == ST_W_DATA) || (s == ST_R_ADDR);
    endfunction

endpackage

`default_nettype wire

// File: rtl/uart_cmd_timer.sv
// ============================================================================
//  Module  : uart_cmd_timer
//  Brief   : Loadable saturating down-counter; done is high while count is 0.
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module uart_cmd_timer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             enable,
    output logic             done
);

    logic [WIDTH-1:0] count;

    // Load has priority; counting stops at zero instead of wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (enable && (count != '0)) begin
            count <= count - WIDTH'(1);
        end
    end

    assign done = (count == '0);

endmodule

`default_nettype wire

// File: rtl/uart_cmd_responder.sv
// ============================================================================
//  Module  : uart_cmd_responder
//  Brief   : Parses 'W'/'R' packets from a UART AXI-stream, performs one 8-bit
//            register bus access per packet and returns an ACK/NAK/data byte.
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module uart_cmd_responder
    import uart_cmd_pkg::*;
#(
    parameter int ADDR_WIDTH    = 8,
    parameter int TIMEOUT_CLKS  = 65535,
    parameter int BUS_WAIT_CLKS = 255
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [7:0]            rx_axis_tdata,
    input  logic                  rx_axis_tvalid,
    output logic                  rx_axis_tready,
    input  logic                  rx_error,
    output logic [7:0]            tx_axis_tdata,
    output logic                  tx_axis_tvalid,
    input  logic                  tx_axis_tready,
    output logic [ADDR_WIDTH-1:0] bus_addr,
    output logic [7:0]            bus_wdata,
    output logic                  bus_we,
    output logic                  bus_re,
    input  logic [7:0]            bus_rdata,
    input  logic                  bus_ack,
    output logic                  busy
);

    localparam int TO_W = $clog2(TIMEOUT_CLKS + 1);
    localparam int BW_W = $clog2(BUS_WAIT_CLKS + 1);
    localparam logic [TO_W-1:0] TO_LOAD = TO_W'(TIMEOUT_CLKS);
    localparam logic [BW_W-1:0] BW_LOAD = BW_W'(BUS_WAIT_CLKS);

    state_t                  state;
    state_t                  state_nxt;
    logic                    rx_ready;
    logic                    byte_take;
    logic [ADDR_WIDTH-1:0]   addr_in;
    logic [ADDR_WIDTH-1:0]   addr_reg;
    logic [7:0]              wdata_reg;
    logic [7:0]              rsp_reg;
    logic [7:0]              rsp_nxt;
    logic                    we_reg;
    logic                    re_reg;
    logic                    we_nxt;
    logic                    re_nxt;
    logic                    cmd_write;
    logic                    cmd_write_nxt;
    logic                    addr_load;
    logic                    wdata_load;
    logic                    to_done;
    logic                    wait_done;

    // Address byte is zero-extended or truncated to the bus address width.
    generate
        if (ADDR_WIDTH > 8) begin : g_addr_ext
            assign addr_in = {{(ADDR_WIDTH-8){1'b0}}, rx_axis_tdata};
        end else if (ADDR_WIDTH == 8) begin : g_addr_same
            assign addr_in = rx_axis_tdata;
        end else begin : g_addr_trunc
            assign addr_in = rx_axis_tdata[ADDR_WIDTH-1:0];
        end
    endgenerate

    assign byte_take = rx_axis_tvalid & rx_ready;

    uart_cmd_timer #(
        .WIDTH (TO_W)
    ) u_byte_timeout (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (byte_take || !pkt_phase(state)),
        .load_value (TO_LOAD),
        .enable     (pkt_phase(state)),
        .done       (to_done)
    );

    uart_cmd_timer #(
        .WIDTH (BW_W)
    ) u_bus_wait (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (state != ST_BUS),
        .load_value (BW_LOAD),
        .enable     (state == ST_BUS),
        .done       (wait_done)
    );

    always_comb begin
        state_nxt     = state;
        rsp_nxt       = rsp_reg;
        we_nxt        = 1'b0;
        re_nxt        = 1'b0;
        cmd_write_nxt = cmd_write;
        addr_load     = 1'b0;
        wdata_load    = 1'b0;

        // A receive error aborts any parse in progress, even if a byte is taken alongside it.
        if (rx_phase(state) && rx_error) begin
            state_nxt = ST_RESP;
            rsp_nxt   = RSP_NAK;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (byte_take) begin
                        if (rx_axis_tdata == CMD_WRITE) begin
                            state_nxt     = ST_W_ADDR;
                            cmd_write_nxt = 1'b1;
                        end else if (rx_axis_tdata == CMD_READ) begin
                            state_nxt     = ST_R_ADDR;
                            cmd_write_nxt = 1'b0;
                        end else begin
                            state_nxt = ST_RESP;
                            rsp_nxt   = RSP_NAK;
                        end
                    end
                end
                ST_W_ADDR: begin
                    if (byte_take) begin
                        addr_load = 1'b1;
                        state_nxt = ST_W_DATA;
                    end else if (to_done) begin
                        state_nxt = ST_IDLE;
                    end
                end
                ST_W_DATA: begin
                    if (byte_take) begin
                        wdata_load = 1'b1;
                        we_nxt     = 1'b1;
                        state_nxt  = ST_BUS;
                    end else if (to_done) begin
                        state_nxt = ST_IDLE;
                    end
                end
                ST_R_ADDR: begin
                    if (byte_take) begin
                        addr_load = 1'b1;
                        re_nxt    = 1'b1;
                        state_nxt = ST_BUS;
                    end else if (to_done) begin
                        state_nxt = ST_IDLE;
                    end
                end
                ST_BUS: begin
                    if (bus_ack) begin
                        state_nxt = ST_RESP;
                        rsp_nxt   = cmd_write ? RSP_ACK : bus_rdata;
                    end else if (wait_done) begin
                        state_nxt = ST_RESP;
                        rsp_nxt   = RSP_NAK;
                    end
                end
                ST_RESP: begin
                    if (tx_axis_tready) begin
                        state_nxt = ST_IDLE;
                    end
                end
                default: begin
                    state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    // rx_ready is registered from the next state so it stays low while reset is held.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            rx_ready  <= 1'b0;
            addr_reg  <= '0;
            wdata_reg <= '0;
            rsp_reg   <= '0;
            we_reg    <= 1'b0;
            re_reg    <= 1'b0;
            cmd_write <= 1'b0;
        end else begin
            state     <= state_nxt;
            rx_ready  <= rx_phase(state_nxt);
            rsp_reg   <= rsp_nxt;
            we_reg    <= we_nxt;
            re_reg    <= re_nxt;
            cmd_write <= cmd_write_nxt;
            if (addr_load) begin
                addr_reg <= addr_in;
            end
            if (wdata_load) begin
                wdata_reg <= rx_axis_tdata;
            end
        end
    end

    assign rx_axis_tready = rx_ready;
    assign tx_axis_tdata  = rsp_reg;
    assign tx_axis_tvalid = (state == ST_RESP);
    assign bus_addr       = addr_reg;
    assign bus_wdata      = wdata_reg;
    assign bus_we         = we_reg;
    assign bus_re         = re_reg;
    assign busy           = (state != ST_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_uart_cmd_responder.sv
// ============================================================================
//  Module  : tb_uart_cmd_responder
//  Brief   : Scoreboard bench: packet stimulus pushes expected bus accesses and
//            response bytes; bus-model and tx monitors pop and compare.
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_uart_cmd_responder;

    localparam int ADDR_WIDTH    = 8;
    localparam int TIMEOUT_CLKS  = 40;
    localparam int BUS_WAIT_CLKS = 20;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic [7:0]            rx_axis_tdata;
    logic                  rx_axis_tvalid;
    logic                  rx_axis_tready;
    logic                  rx_error;
    logic [7:0]            tx_axis_tdata;
    logic                  tx_axis_tvalid;
    logic                  tx_axis_tready;
    logic [ADDR_WIDTH-1:0] bus_addr;
    logic [7:0]            bus_wdata;
    logic                  bus_we;
    logic                  bus_re;
    logic [7:0]            bus_rdata;
    logic                  bus_ack;
    logic                  busy;
    logic                  model_ack;
    logic                  manual_ack;

    assign bus_ack = model_ack | manual_ack;

    always #5 clk = ~clk;

    uart_cmd_responder #(
        .ADDR_WIDTH    (ADDR_WIDTH),
        .TIMEOUT_CLKS  (TIMEOUT_CLKS),
        .BUS_WAIT_CLKS (BUS_WAIT_CLKS)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .rx_axis_tdata  (rx_axis_tdata),
        .rx_axis_tvalid (rx_axis_tvalid),
        .rx_axis_tready (rx_axis_tready),
        .rx_error       (rx_error),
        .tx_axis_tdata  (tx_axis_tdata),
        .tx_axis_tvalid (tx_axis_tvalid),
        .tx_axis_tready (tx_axis_tready),
        .bus_addr       (bus_addr),
        .bus_wdata      (bus_wdata),
        .bus_we         (bus_we),
        .bus_re         (bus_re),
        .bus_rdata      (bus_rdata),
        .bus_ack        (bus_ack),
        .busy           (busy)
    );

    typedef struct packed {
        logic       we;
        logic [7:0] addr;
        logic [7:0] data;
    } bus_exp_t;

    int         vectors     = 0;
    int         miscompares = 0;
    logic [7:0] model_mem [256];
    logic [7:0] dev_mem   [256];
    bus_exp_t   bus_q [$];
    logic [7:0] tx_q  [$];
    bit         ack_enable  = 1'b1;
    bit         ack_random  = 1'b0;
    int         ack_delay   = 1;
    bit         tx_hold_low = 1'b0;
    logic       prev_strobe = 1'b0;
    logic       prev_hold   = 1'b0;
    logic [7:0] prev_data   = 8'h00;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Response sink with random backpressure unless explicitly held off.
    always @(posedge clk) begin
        #1;
        tx_axis_tready = tx_hold_low ? 1'b0 : ($urandom_range(3) != 0);
    end

    // Response monitor: holds stability while stalled, pops the scoreboard on handshake.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_hold = 1'b0;
        end else begin
            if (prev_hold) begin
                check("tx_valid_held", {31'd0, tx_axis_tvalid}, 32'd1);
                check("tx_data_stable", {24'd0, tx_axis_tdata}, {24'd0, prev_data});
            end
            if (tx_axis_tvalid && tx_axis_tready) begin
                if (tx_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL tx_unexpected: got %02h, expected no byte at %0t", tx_axis_tdata, $time);
                end else begin
                    check("tx_byte", {24'd0, tx_axis_tdata}, {24'd0, tx_q.pop_front()});
                end
            end
            prev_hold = tx_axis_tvalid && !tx_axis_tready;
            prev_data = tx_axis_tdata;
        end
    end

    always @(negedge clk) begin
        if (rst_n && (bus_we || bus_re)) begin
            check("strobe_one_cycle", {31'd0, prev_strobe}, 32'd0);
        end
        prev_strobe = rst_n && (bus_we || bus_re);
    end

    // Register-bus device: checks each strobe against the scoreboard, then acks.
    initial begin
        bus_exp_t   e;
        logic [7:0] a;
        int         d;
        model_ack = 1'b0;
        bus_rdata = 8'h00;
        forever begin
            @(negedge clk);
            if (rst_n && (bus_we || bus_re)) begin
                a = bus_addr;
                if (bus_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL bus_unexpected: got we=%0b re=%0b addr=%02h, expected no access", bus_we, bus_re, bus_addr);
                end else begin
                    e = bus_q.pop_front();
                    check("bus_we", {31'd0, bus_we}, {31'd0, e.we});
                    check("bus_re", {31'd0, bus_re}, {31'd0, !e.we});
                    check("bus_addr", {24'd0, bus_addr}, {24'd0, e.addr});
                    if (e.we) check("bus_wdata", {24'd0, bus_wdata}, {24'd0, e.data});
                end
                if (bus_we) dev_mem[a] = bus_wdata;
                if (ack_enable) begin
                    d = ack_random ? $urandom_range(1, 5) : ack_delay;
                    repeat (d) @(posedge clk);
                    #1;
                    model_ack = 1'b1;
                    bus_rdata = dev_mem[a];
                    @(negedge clk);
                    check("bus_addr_hold", {24'd0, bus_addr}, {24'd0, a});
                    @(posedge clk);
                    #1;
                    model_ack = 1'b0;
                    bus_rdata = 8'($urandom);
                end
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input bit err);
        int n = 0;
        rx_axis_tdata  = b;
        rx_axis_tvalid = 1'b1;
        rx_error       = err;
        @(negedge clk);
        while (!rx_axis_tready && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (!rx_axis_tready) begin
            vectors++;
            miscompares++;
            $display("FAIL rx_accept_timeout: byte %02h not accepted, expected acceptance", b);
        end
        @(posedge clk);
        #1;
        rx_axis_tvalid = 1'b0;
        rx_error       = 1'b0;
    endtask

    task automatic do_write(input logic [7:0] a, input logic [7:0] d);
        bus_q.push_back('{we: 1'b1, addr: a, data: d});
        tx_q.push_back(8'h06);
        model_mem[a] = d;
        send_byte(8'h57, 1'b0);
        idle($urandom_range(0, 3));
        send_byte(a, 1'b0);
        idle($urandom_range(0, 3));
        send_byte(d, 1'b0);
    endtask

    task automatic do_read(input logic [7:0] a);
        bus_q.push_back('{we: 1'b0, addr: a, data: 8'h00});
        tx_q.push_back(model_mem[a]);
        send_byte(8'h52, 1'b0);
        idle($urandom_range(0, 3));
        send_byte(a, 1'b0);
    endtask

    task automatic drain();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(tx_q.size() == 0 && bus_q.size() == 0 && !busy) && n < 2000);
        if (n >= 2000) begin
            vectors++;
            miscompares++;
            $display("FAIL drain_timeout: %0d tx and %0d bus pending, expected 0", tx_q.size(), bus_q.size());
        end
        idle(1);
    endtask

    task automatic check_reset_outputs();
        @(negedge clk);
        check("rst_rx_tready", {31'd0, rx_axis_tready}, 32'd0);
        check("rst_tx_tvalid", {31'd0, tx_axis_tvalid}, 32'd0);
        check("rst_tx_tdata", {24'd0, tx_axis_tdata}, 32'd0);
        check("rst_bus_addr", {24'd0, bus_addr}, 32'd0);
        check("rst_bus_wdata", {24'd0, bus_wdata}, 32'd0);
        check("rst_bus_strobes", {30'd0, bus_we, bus_re}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, expected finish");
        $fatal(1);
    end

    initial begin
        logic [7:0] cap;
        logic [7:0] a;
        int         n;
        int         kind;
        for (int i = 0; i < 256; i++) begin
            cap          = 8'($urandom);
            model_mem[i] = cap;
            dev_mem[i]   = cap;
        end
        rst_n          = 1'b0;
        rx_axis_tdata  = 8'h00;
        rx_axis_tvalid = 1'b0;
        rx_error       = 1'b0;
        manual_ack     = 1'b0;
        tx_axis_tready = 1'b0;
        check_reset_outputs();
        idle(2);
        rst_n = 1'b1;
        idle(2);

        // 1: write with ack after one cycle
        ack_delay = 1;
        do_write(8'h10, 8'hA5);
        drain();

        // 2: read with ack after three cycles; rx_error during BUS is ignored
        model_mem[8'h10] = 8'h3C;
        dev_mem[8'h10]   = 8'h3C;
        ack_delay = 3;
        do_read(8'h10);
        rx_error = 1'b1;
        idle(1);
        rx_error = 1'b0;
        drain();

        // 3: unknown command then a normal read
        tx_q.push_back(8'h15);
        send_byte(8'h41, 1'b0);
        do_read(8'h20);
        drain();

        // 4: abandoned packet times out silently
        send_byte(8'h57, 1'b0);
        send_byte(8'h10, 1'b0);
        idle(2 * TIMEOUT_CLKS + 10);
        @(negedge clk);
        check("timeout_busy", {31'd0, busy}, 32'd0);
        check("timeout_rx_ready", {31'd0, rx_axis_tready}, 32'd1);
        idle(1);
        do_read(8'h10);
        drain();

        // 5a: bus never acks -> NAK
        ack_enable = 1'b0;
        bus_q.push_back('{we: 1'b0, addr: 8'h44, data: 8'h00});
        tx_q.push_back(8'h15);
        send_byte(8'h52, 1'b0);
        send_byte(8'h44, 1'b0);
        drain();
        ack_enable = 1'b1;

        // 5b: response held off for 50 cycles
        tx_hold_low = 1'b1;
        do_read(8'h55);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!tx_axis_tvalid && n < 200);
        check("hold_tvalid_seen", {31'd0, tx_axis_tvalid}, 32'd1);
        cap = tx_axis_tdata;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            check("hold_rx_tready", {31'd0, rx_axis_tready}, 32'd0);
            check("hold_tdata", {24'd0, tx_axis_tdata}, {24'd0, cap});
        end
        @(posedge clk);
        #1;
        tx_hold_low = 1'b0;
        drain();

        // 6: reset during BUS, late ack must be ignored
        ack_enable = 1'b0;
        bus_q.push_back('{we: 1'b0, addr: 8'h30, data: 8'h00});
        send_byte(8'h52, 1'b0);
        send_byte(8'h30, 1'b0);
        idle(2);
        rst_n = 1'b0;
        check_reset_outputs();
        idle(3);
        rst_n = 1'b1;
        idle(1);
        manual_ack = 1'b1;
        idle(1);
        manual_ack = 1'b0;
        ack_enable = 1'b1;
        idle(30);
        @(negedge clk);
        check("post_reset_busy", {31'd0, busy}, 32'd0);
        idle(1);
        do_write(8'h11, 8'h5A);
        drain();

        // Randomized traffic
        ack_random = 1'b1;
        for (int t = 0; t < 80; t++) begin
            kind = $urandom_range(0, 9);
            a    = 8'($urandom);
            if (kind < 4) begin
                do_write(a, 8'($urandom));
            end else if (kind < 8) begin
                do_read(a);
            end else if (kind == 8) begin
                cap = 8'($urandom);
                if (cap == 8'h57 || cap == 8'h52) cap = 8'h00;
                tx_q.push_back(8'h15);
                send_byte(cap, 1'b0);
            end else begin
                tx_q.push_back(8'h15);
                if ($urandom_range(1) == 1) begin
                    send_byte(8'h57, 1'b0);
                    if ($urandom_range(1) == 1) send_byte(a, 1'b0);
                end else begin
                    send_byte(8'h52, 1'b0);
                end
                send_byte(8'($urandom), 1'b1);
            end
            idle($urandom_range(0, 3));
        end
        drain();
        check("final_tx_queue", tx_q.size(), 32'd0);
        check("final_bus_queue", bus_q.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
